// File: rtl/datapath_pkg.sv
// -----------------------------------------------------------------------------
// datapath_pkg
// Shared definitions for the multi-cycle datapath: command opcodes, the control
// FSM state encoding, and small decode helpers. The helpers choose the second
// ALU operand and the add/subtract direction.
// -----------------------------------------------------------------------------
package datapath_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_LD   = 3'b011;
  localparam logic [2:0] OP_SD   = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EXEC = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  // Opcodes 101..111 are reserved.
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= OP_SD);
  endfunction

  // ADD/SUB take register B; ADDI/LD/SD take the immediate.
  function automatic logic op2_sel_imm(input logic [2:0] op);
    return !((op == OP_ADD) || (op == OP_SUB));
  endfunction

  function automatic logic alu_is_sub(input logic [2:0] op);
    return (op == OP_SUB);
  endfunction

  function automatic logic op_is_mem(input logic [2:0] op);
    return (op == OP_LD) || (op == OP_SD);
  endfunction

endpackage

// File: rtl/banco_registradores_param.sv
// -----------------------------------------------------------------------------
// banco_registradores_param
// Register bank with two combinational read ports and one synchronous write
// port. x0 is hardwired to zero: reads of it return 0 and writes to it are
// dropped. A synchronous active-low reset clears x1..x(NREGS-1).
//
// Ports:
//   i_clk, i_rst_n    clock, synchronous active-low clear
//   i_ra1, i_ra2      read addresses
//   o_rd1, o_rd2      read data (combinational)
//   i_we, i_wa, i_wd  write enable, address, data (applied at rising edge)
// -----------------------------------------------------------------------------
module banco_registradores_param #(
  parameter  int XLEN  = 64,
  parameter  int NREGS = 32,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [RW-1:0]   i_ra1,
  input  logic [RW-1:0]   i_ra2,
  output logic [XLEN-1:0] o_rd1,
  output logic [XLEN-1:0] o_rd2,
  input  logic            i_we,
  input  logic [RW-1:0]   i_wa,
  input  logic [XLEN-1:0] i_wd
);

  // x0 has no storage.
  logic [XLEN-1:0] r_regs [1:NREGS-1];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 1; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_wa != '0)) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  assign o_rd1 = (i_ra1 == '0) ? '0 : r_regs[i_ra1];
  assign o_rd2 = (i_ra2 == '0) ? '0 : r_regs[i_ra2];

endmodule

// File: rtl/datapath_multiciclo.sv
// -----------------------------------------------------------------------------
// datapath_multiciclo
// Multi-cycle RISC-V style datapath. It contains a register bank, an
// adder/subtractor and a data memory, sequenced by an internal FSM:
//   IDLE -> READ -> EXEC -> WB           (ADD, SUB, ADDI)
//   IDLE -> READ -> EXEC -> MEM          (SD)
//   IDLE -> READ -> EXEC -> MEM -> WB    (LD)
//   IDLE -> ERR                          (illegal opcode)
//
// Handshake: a command is accepted on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE and out of reset.
// All cmd_* fields are captured at acceptance and ignored afterwards. A
// cmd_valid held high while the block is busy is therefore not consumed again.
// done pulses for one cycle in the command's final cycle. err and result are
// meaningful only while done is high.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_op                000 ADD, 001 SUB, 010 ADDI, 011 LD, 100 SD
//   cmd_rs1/rs2/rd        register indices
//   cmd_imm               immediate / address offset
//   done, err, result     completion pulse, illegal-op flag, result value
//   o_dbg_state           current FSM state (observation only)
// -----------------------------------------------------------------------------
module datapath_multiciclo
  import datapath_pkg::*;
#(
  parameter  int XLEN      = 64,
  parameter  int NREGS     = 32,
  parameter  int MEM_DEPTH = 256,
  localparam int RW        = $clog2(NREGS),
  localparam int AW        = $clog2(MEM_DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_op,
  input  logic [RW-1:0]   cmd_rs1,
  input  logic [RW-1:0]   cmd_rs2,
  input  logic [RW-1:0]   cmd_rd,
  input  logic [XLEN-1:0] cmd_imm,
  output logic            done,
  output logic            err,
  output logic [XLEN-1:0] result,
  output state_t          o_dbg_state
);

  state_t          r_state;
  state_t          w_next_state;

  logic [2:0]      r_op;
  logic [RW-1:0]   r_rs1;
  logic [RW-1:0]   r_rs2;
  logic [RW-1:0]   r_rd;
  logic [XLEN-1:0] r_imm;

  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_alu;
  logic [XLEN-1:0] r_mem_rdata;
  logic [XLEN-1:0] r_mem [MEM_DEPTH];

  logic            w_accept;
  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;
  logic [XLEN-1:0] w_op2;
  logic [XLEN-1:0] w_alu;
  logic [XLEN-1:0] w_wb_data;
  logic [AW-1:0]   w_mem_addr;
  logic            w_mem_we;
  logic            w_reg_we;

  assign w_accept = cmd_valid && cmd_ready;

  // ---------------------------------------------------------------------------
  // Register bank
  // ---------------------------------------------------------------------------
  banco_registradores_param #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regs (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_ra1   (r_rs1),
    .i_ra2   (r_rs2),
    .o_rd1   (w_rd1),
    .o_rd2   (w_rd2),
    .i_we    (w_reg_we),
    .i_wa    (r_rd),
    .i_wd    (w_wb_data)
  );

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Command capture and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op  <= '0;
      r_rs1 <= '0;
      r_rs2 <= '0;
      r_rd  <= '0;
      r_imm <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_alu <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= cmd_op;
        r_rs1 <= cmd_rs1;
        r_rs2 <= cmd_rs2;
        r_rd  <= cmd_rd;
        r_imm <= cmd_imm;
      end
      if (r_state == ST_READ) begin
        r_a <= w_rd1;
        r_b <= w_rd2;
      end
      if (r_state == ST_EXEC) begin
        r_alu <= w_alu;
      end
    end
  end

  // Arithmetic wraps modulo 2^XLEN; carry-out is dropped.
  assign w_op2 = op2_sel_imm(r_op) ? r_imm : r_b;
  assign w_alu = alu_is_sub(r_op) ? (r_a - w_op2) : (r_a + w_op2);

  // ---------------------------------------------------------------------------
  // Data memory. Its contents survive reset. The address keeps the low AW bits
  // of the effective address, so out-of-range addresses wrap.
  // ---------------------------------------------------------------------------
  assign w_mem_addr = r_alu[AW-1:0];
  assign w_mem_we   = rst_n && (r_state == ST_MEM) && (r_op == OP_SD);

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= r_b;
    end
    if ((r_state == ST_MEM) && (r_op == OP_LD)) begin
      r_mem_rdata <= r_mem[w_mem_addr];
    end
  end

  // Write-back. Gating with rst_n drops a write that coincides with reset.
  assign w_wb_data = (r_op == OP_LD) ? r_mem_rdata : r_alu;
  assign w_reg_we  = rst_n && (r_state == ST_WB);

  // ---------------------------------------------------------------------------
  // FSM next-state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    cmd_ready    = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    result       = '0;

    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_next_state = op_is_legal(cmd_op) ? ST_READ : ST_ERR;
        end
      end
      ST_READ: begin
        w_next_state = ST_EXEC;
      end
      ST_EXEC: begin
        w_next_state = op_is_mem(r_op) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        if (r_op == OP_SD) begin
          done         = 1'b1;
          result       = r_alu;
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_WB;
        end
      end
      ST_WB: begin
        done         = 1'b1;
        result       = w_wb_data;
        w_next_state = ST_IDLE;
      end
      ST_ERR: begin
        done         = 1'b1;
        err          = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase

    // While reset is held, the block neither offers a handshake nor reports
    // completion.
    if (!rst_n) begin
      cmd_ready = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      result    = '0;
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_datapath_multiciclo.sv
module tb_datapath_multiciclo;
  import datapath_pkg::*;

  localparam int XLEN      = 64;
  localparam int NREGS     = 32;
  localparam int MEM_DEPTH = 256;
  localparam int RW        = 5;
  localparam int EW        = 1 + 32 + XLEN;  // {err, done_cycle, result}

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic            clk;
  logic            rst_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_op;
  logic [RW-1:0]   cmd_rs1;
  logic [RW-1:0]   cmd_rs2;
  logic [RW-1:0]   cmd_rd;
  logic [XLEN-1:0] cmd_imm;
  logic            done;
  logic            err;
  logic [XLEN-1:0] result;
  state_t          dbg_state;

  datapath_multiciclo #(
    .XLEN      (XLEN),
    .NREGS     (NREGS),
    .MEM_DEPTH (MEM_DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_rs1     (cmd_rs1),
    .cmd_rs2     (cmd_rs2),
    .cmd_rd      (cmd_rd),
    .cmd_imm     (cmd_imm),
    .done        (done),
    .err         (err),
    .result      (result),
    .o_dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse consumes one expectation.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL unexpected_done: result 0x%0h err %0b at cycle %0d", result, err, cyc);
      end else begin
        e = exp_q.pop_front();
        check("result", result, e[XLEN-1:0]);
        check("err", 64'(err), 64'(e[EW-1]));
        check("done_cycle", 64'(cyc), 64'(e[XLEN+31:XLEN]));
      end
    end else if (err) begin
      n_cmp++;
      n_mis++;
      $display("FAIL err_without_done: err 1 done 0 at cycle %0d", cyc);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic wait_idle();
    int budget;
    budget = 0;
    @(negedge clk);
    while (!((exp_q.size() == 0) && cmd_ready) && (budget < 20)) begin
      @(negedge clk);
      budget++;
    end
    if (!((exp_q.size() == 0) && cmd_ready)) begin
      n_cmp++;
      n_mis++;
      $display("FAIL idle_timeout: pending %0d ready %0b", exp_q.size(), cmd_ready);
      exp_q.delete();
    end
  endtask

  // Issue one command. lat is the expected distance from acceptance to done.
  // With hold=1, cmd_valid stays high through the busy period.
  task automatic send(input logic [2:0] op, input int rs1, input int rs2, input int rd,
                      input logic [XLEN-1:0] imm, input logic [XLEN-1:0] exp_res,
                      input logic exp_err, input int lat, input bit hold);
    int t;
    int budget;
    @(negedge clk);
    cmd_op    = op;
    cmd_rs1   = rs1[RW-1:0];
    cmd_rs2   = rs2[RW-1:0];
    cmd_rd    = rd[RW-1:0];
    cmd_imm   = imm;
    cmd_valid = 1'b1;
    budget = 0;
    while (!cmd_ready && (budget < 50)) begin
      @(negedge clk);
      budget++;
    end
    if (!cmd_ready) begin
      n_cmp++;
      n_mis++;
      $display("FAIL accept_timeout: ready 0 after %0d cycles", budget);
      cmd_valid = 1'b0;
      return;
    end
    t = cyc;
    exp_q.push_back({exp_err, 32'(t + lat), exp_res});
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
    check("ready_low_after_accept", 64'(cmd_ready), 64'(0));
    // Fields must already be latched, so garbage here must not matter.
    cmd_op  = 3'($urandom_range(0, 7));
    cmd_rs1 = RW'($urandom_range(0, NREGS - 1));
    cmd_rs2 = RW'($urandom_range(0, NREGS - 1));
    cmd_rd  = RW'($urandom_range(0, NREGS - 1));
    cmd_imm = {$urandom, $urandom};
    if (lat == 1) begin
      @(negedge clk);
      check("ready_back_after_err", 64'(cmd_ready), 64'(1));
    end
    if (hold) begin
      while (cyc < t + lat) @(negedge clk);
      cmd_valid = 1'b0;
    end
    wait_idle();
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_rs1   = '0;
    cmd_rs2   = '0;
    cmd_rd    = '0;
    cmd_imm   = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", 64'(cmd_ready), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_err", 64'(err), 64'(0));
    check("reset_result", result, 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'(cmd_ready), 64'(1));
    check("state_after_reset", 64'(dbg_state), 64'(ST_IDLE));

    // ALU ops
    send(OP_ADDI, 0, 0, 1, 64'd5, 64'd5, 1'b0, 3, 1'b0);
    send(OP_ADDI, 0, 0, 2, 64'd7, 64'd7, 1'b0, 3, 1'b0);
    send(OP_SUB,  1, 2, 3, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 3, 1'b0);
    send(OP_ADD,  3, 0, 0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 3, 1'b0);
    // Wrap past 2^64: -2 + 3 = 1
    send(OP_ADDI, 3, 0, 10, 64'd3, 64'd1, 1'b0, 3, 1'b0);

    // Store / load
    send(OP_SD, 0, 1, 0, 64'd10, 64'd10, 1'b0, 3, 1'b0);
    send(OP_LD, 0, 0, 4, 64'd10, 64'd5, 1'b0, 4, 1'b0);
    send(OP_ADD, 4, 0, 0, 64'd0, 64'd5, 1'b0, 3, 1'b0);

    // Address wrap: MEM_DEPTH+3 aliases word 3
    send(OP_ADDI, 0, 0, 8, 64'h1234, 64'h1234, 1'b0, 3, 1'b0);
    send(OP_SD, 0, 8, 0, 64'(MEM_DEPTH + 3), 64'(MEM_DEPTH + 3), 1'b0, 3, 1'b0);
    send(OP_LD, 0, 0, 9, 64'd3, 64'h1234, 1'b0, 4, 1'b0);

    // Base register + offset: x11=7, [7+3] <= x2 (7)
    send(OP_ADDI, 0, 0, 11, 64'd7, 64'd7, 1'b0, 3, 1'b0);
    send(OP_SD, 11, 2, 0, 64'd3, 64'd10, 1'b0, 3, 1'b0);
    send(OP_LD, 11, 0, 12, 64'd3, 64'd7, 1'b0, 4, 1'b0);

    // x0 is immutable
    send(OP_ADDI, 0, 0, 0, 64'd9, 64'd9, 1'b0, 3, 1'b0);
    send(OP_ADD,  0, 0, 5, 64'd0, 64'd0, 1'b0, 3, 1'b0);
    send(OP_ADD,  5, 0, 0, 64'd0, 64'd0, 1'b0, 3, 1'b0);

    // Illegal opcodes, then confirm x1 untouched
    send(3'b111, 1, 1, 1, 64'd99, 64'd0, 1'b1, 1, 1'b0);
    send(3'b101, 2, 2, 2, 64'd99, 64'd0, 1'b1, 1, 1'b0);
    send(OP_ADD, 1, 0, 0, 64'd0, 64'd5, 1'b0, 3, 1'b0);

    // cmd_valid held through busy period: exactly one done expected
    send(OP_ADDI, 0, 0, 13, 64'd42, 64'd42, 1'b0, 3, 1'b1);
    send(OP_ADD, 13, 0, 0, 64'd0, 64'd42, 1'b0, 3, 1'b0);

    // Reset during EXEC of ADDI x6,x0,1
    @(negedge clk);
    cmd_op    = OP_ADDI;
    cmd_rs1   = 5'd0;
    cmd_rs2   = 5'd0;
    cmd_rd    = 5'd6;
    cmd_imm   = 64'd1;
    cmd_valid = 1'b1;
    check("ready_before_abort", 64'(cmd_ready), 64'(1));
    @(negedge clk);
    check("state_read", 64'(dbg_state), 64'(ST_READ));
    @(negedge clk);
    check("state_exec", 64'(dbg_state), 64'(ST_EXEC));
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("abort_done", 64'(done), 64'(0));
    check("abort_ready", 64'(cmd_ready), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready_after_release", 64'(cmd_ready), 64'(1));
    check("abort_state_idle", 64'(dbg_state), 64'(ST_IDLE));
    check("abort_no_done", 64'(done), 64'(0));
    send(OP_ADD, 6, 0, 0, 64'd0, 64'd0, 1'b0, 3, 1'b0);   // x6 never written
    send(OP_ADD, 1, 0, 0, 64'd0, 64'd0, 1'b0, 3, 1'b0);   // x1 cleared by reset
    send(OP_LD, 0, 0, 14, 64'd10, 64'd7, 1'b0, 4, 1'b0);  // memory retained

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL leftover_expectations: %0d never completed", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/datapath_multiciclo.md
# datapath_multiciclo

Parametrised multi-cycle successor of the single-cycle RISC-V datapath: register bank, adder/subtractor, data memory and an internal control FSM behind a valid/ready command port. Each accepted command (ADD, SUB, ADDI, LD, SD) is executed through registered READ/EXEC/MEM/WB states, so the block accepts external commands instead of raw mux/enable strobes. It sits between the future instruction decoder and the register/memory subsystem.

## Interface
- XLEN, 64, data/register width
- NREGS, 32, number of architectural registers; RW = clog2(NREGS)
- MEM_DEPTH, 256, data memory depth in XLEN-bit words; AW = clog2(MEM_DEPTH)

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  one clock; reset is synchronous and active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd_op  in  3  000 ADD, 001 SUB, 010 ADDI, 011 LD, 100 SD, others illegal
- cmd_rs1  in  RW  first source register (base for LD/SD)
- cmd_rs2  in  RW  second source (store data for SD)
- cmd_rd  in  RW  destination register
- cmd_imm  in  XLEN  immediate (ADDI, LD, SD offset)
- done  out  1  one-cycle pulse in a command's final cycle
- err  out  1  qualifies done: illegal opcode
- result  out  XLEN  ALU sum, LD data, or SD address; valid while done

## Operation
- Accept on cmd_valid & cmd_ready; all cmd_* fields latched, inputs ignored afterwards.
- States: IDLE, READ, EXEC, MEM, WB, ERR.
- IDLE -> READ on accept (legal op); IDLE -> ERR on accept (illegal op).
- READ: A <= reg[rs1], B <= reg[rs2]; reads of x0 return 0.
- EXEC: ALUOut <= A + op2 (ADD, ADDI, LD, SD) or A - op2 (SUB); op2 = B for ADD/SUB, imm otherwise. Arithmetic modulo 2^XLEN, carry/overflow discarded.
- EXEC -> WB for ADD/SUB/ADDI; EXEC -> MEM for LD/SD.
- MEM: address = ALUOut[AW-1:0] (upper bits ignored, wraps). SD writes B at end of cycle, done=1, result=ALUOut, -> IDLE. LD issues synchronous read, -> WB.
- WB: reg[rd] <= ALUOut (ALU ops) or mem read data (LD) at end of cycle; done=1, result = written value; writes to x0 discarded (done still pulses). -> IDLE.
- ERR: done=1, err=1, result=0, no register/memory write, -> IDLE.
- Back-to-back commands on same registers need no forwarding: commands are fully serialised.

## Timing
- Accept in cycle T. ADD/SUB/ADDI: done in T+3, register updated at end of T+3. SD: done in T+3, memory updated at end of T+3. LD: done in T+4. Illegal: done/err in T+1.
- cmd_ready high again the cycle after done; max ALU throughput one command per 4 cycles.
- Reset (rst_n=0 at an edge): state <= IDLE, all registers x1..x(NREGS-1) <= 0, cmd_ready/done/err/result <= 0; memory contents retained.
- Reset mid-command: command abandoned; register/memory write scheduled for that cycle is suppressed; no done pulse.
- First cycle after reset release: cmd_ready=1.

## Structure
- Package datapath_pkg: opcode constants, state enum, op2-select and add/sub select decode helper.
- Sub-module banco_registradores_param (parameters XLEN, NREGS): two combinational reads, one synchronous write, x0 hardwired, synchronous clear on rst_n. Memory and adder inline or existing modules widened by XLEN.

## Test plan
- Reset, then ADDI x1,x0,5 -> done at T+3, result=5, reg x1=5; ADDI x2,x0,7; SUB x3,x1,x2 -> result=0xFFFF_FFFF_FFFF_FFFE.
- SD x1 -> [x0+10], then LD x4,[x0+10] -> SD done T+3 result=10; LD done T+4 result=5, x4=5.
- Address wrap: SD to imm=MEM_DEPTH+3 then LD imm=3 -> returns stored value.
- ADDI x0,x0,9 then ADD x5,x0,x0 -> done pulses, x5=0.
- cmd_op=111 -> done=err=1 at T+1, no state change; cmd_ready low for T+1 only.
- Assert rst_n=0 during EXEC of ADDI x6,x0,1 -> no done, x6=0, cmd_ready=1 after release; cmd_valid held during busy not accepted twice.
